// File: rtl/number_overlay_ctrl_pkg.sv
// Shared constants, FSM encodings and helpers for the number overlay controller.
package number_overlay_ctrl_pkg;

  localparam int FETCH_SLOTS = 6;
  localparam int DIGITS      = 3;
  localparam int GLYPH_W     = 8;
  localparam int GLYPH_H     = 16;
  localparam int STATE_W     = 2;

  // Conversion FSM encodings
  localparam logic [STATE_W-1:0] C_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] C_CONV0 = 2'd1;
  localparam logic [STATE_W-1:0] C_CONV1 = 2'd2;

  // Fetch FSM encodings
  localparam logic [STATE_W-1:0] F_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] F_FETCH = 2'd1;
  localparam logic [STATE_W-1:0] F_DONE  = 2'd2;

  // char_rom address packing: {digit, glyph_line}
  function automatic logic [7:0] rom_pack(input logic [3:0] digit, input logic [3:0] line);
    return {digit, line};
  endfunction

  // One double-dabble step on {hundreds, tens, ones, binary}: add 3 to BCD nibbles >= 5, then shift
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] a;
    a = v;
    for (int i = 0; i < 3; i++) begin
      if (a[8+4*i +: 4] >= 4'd5) a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  // Digit value of fetch slot s (0..2 = field 0 hundreds/tens/ones, 3..5 = field 1)
  function automatic logic [3:0] slot_digit(input logic [2:0] s, input logic [11:0] b0,
                                            input logic [11:0] b1);
    logic [11:0] b;
    logic [2:0]  d;
    logic [3:0]  r;
    b = (s >= 3'd3) ? b1 : b0;
    d = (s >= 3'd3) ? s - 3'd3 : s;
    case (d)
      3'd0:    r = b[11:8];
      3'd1:    r = b[7:4];
      default: r = b[3:0];
    endcase
    return r;
  endfunction

  // Leading-zero suppression for slot s; the ones digit is never blanked
  function automatic logic slot_blank(input logic [2:0] s, input logic [11:0] b0,
                                      input logic [11:0] b1, input logic lead);
    logic [11:0] b;
    logic [2:0]  d;
    logic        r;
    b = (s >= 3'd3) ? b1 : b0;
    d = (s >= 3'd3) ? s - 3'd3 : s;
    case (d)
      3'd0:    r = (b[11:8] == 4'd0);
      3'd1:    r = (b[11:8] == 4'd0) && (b[7:4] == 4'd0);
      default: r = 1'b0;
    endcase
    return r && lead;
  endfunction

endpackage

// File: rtl/number_overlay_ctrl_if.sv
// Video timing, char_rom and pixel signals of the number overlay controller.
// Timing contract: there is no valid/ready handshake; every input is sampled on each
// pclk rising edge, rom_data must be the combinational glyph row for the rom_addr
// presented in that same cycle, and pixel/pixel_fld are registered one pclk after hcount.
interface number_overlay_ctrl_if;
  import number_overlay_ctrl_pkg::*;

  logic [7:0]         number0;
  logic [7:0]         number1;
  logic [10:0]        hcount;
  logic [10:0]        vcount;
  logic               hblnk;
  logic               vblnk;
  logic [7:0]         rom_addr;
  logic [7:0]         rom_data;
  logic               pixel;
  logic               pixel_fld;
  logic               conv_busy;
  logic [STATE_W-1:0] conv_state;
  logic [STATE_W-1:0] fetch_state;

  modport master (
    output number0, number1, hcount, vcount, hblnk, vblnk, rom_data,
    input  rom_addr, pixel, pixel_fld, conv_busy, conv_state, fetch_state
  );

  modport slave (
    input  number0, number1, hcount, vcount, hblnk, vblnk, rom_data,
    output rom_addr, pixel, pixel_fld, conv_busy, conv_state, fetch_state
  );
endinterface

// File: rtl/number_overlay_ctrl_bin2bcd_seq.sv
// Serial 8-bit binary to 3-digit BCD converter, 8 shift cycles per conversion.
// The first shift happens on the start edge, so done is high in the cycle after the
// eighth shift and bcd holds the result until the next start.
module bin2bcd_seq
  import number_overlay_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  logic [19:0] sr;
  logic [2:0]  cnt;

  // Load-and-shift on start, then shift until eight steps are complete
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      sr   <= dd_step({12'd0, bin});
      cnt  <= 3'd1;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      sr   <= dd_step(sr);
      cnt  <= cnt + 3'd1;
      busy <= (cnt != 3'd7);
      done <= (cnt == 3'd7);
    end else begin
      done <= 1'b0;
    end
  end

  assign bcd = sr[19:8];

endmodule

// File: rtl/number_overlay_ctrl.sv
// Two 3-digit number fields sharing one char_rom: BCD conversion in vblank,
// glyph-row prefetch in hblank, registered pixel stream during the active line.
module number_overlay_ctrl
  import number_overlay_ctrl_pkg::*;
#(
  parameter logic [10:0] XPOS0      = 11'd0,
  parameter logic [10:0] YPOS0      = 11'd0,
  parameter logic [10:0] XPOS1      = 11'd400,
  parameter logic [10:0] YPOS1      = 11'd0,
  parameter int          SCALE_LOG2 = 3,
  parameter logic [10:0] V_LAST     = 11'd627,
  parameter bit          LEAD_BLANK = 1'b1
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  number_overlay_ctrl_if.slave io
);

  localparam logic [10:0] FIELD_W = 11'(DIGITS * (GLYPH_W << SCALE_LOG2));
  localparam logic [10:0] WIN_H   = 11'(GLYPH_H << SCALE_LOG2);

  logic hblnk_q, vblnk_q, hrise, hfall, vrise;

  logic [STATE_W-1:0] cstate, fstate;
  logic [7:0]  n1_lat;
  logic [11:0] bcd0_tmp, disp0, disp1;
  logic        cvt_start, cvt_busy, cvt_done;
  logic [7:0]  cvt_bin;
  logic [11:0] cvt_bcd;

  logic [2:0]  slot, nslot, pslot;
  logic [3:0]  line0, line1, line0_t, line1_t;
  logic        hit0, hit1, hit0_t, hit1_t, cur_keep;
  logic [7:0]  naddr, taddr;
  logic [FETCH_SLOTS-1:0][7:0] shadow, active;

  logic [10:0] nl, dsel;
  logic [11:0] dy0, dy1, px0, px1;
  logic        in0, in1, pix_on;
  logic [1:0]  dig;
  logic [2:0]  bsel;

  assign hrise = io.hblnk & ~hblnk_q;
  assign hfall = ~io.hblnk & hblnk_q;
  assign vrise = io.vblnk & ~vblnk_q;

  // Blanking edge detectors
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
    end else begin
      hblnk_q <= io.hblnk;
      vblnk_q <= io.vblnk;
    end
  end

  // Field 0 is converted straight from the port on the vblank edge; field 1 from its latch
  assign cvt_start = ((cstate == C_IDLE) && vrise && !cvt_busy) ||
                     ((cstate == C_CONV0) && cvt_done);
  assign cvt_bin   = (cstate == C_IDLE) ? io.number0 : n1_lat;

  bin2bcd_seq u_bcd (
    .clk   (pclk),
    .rst_n (rst_n),
    .start (cvt_start),
    .bin   (cvt_bin),
    .busy  (cvt_busy),
    .done  (cvt_done),
    .bcd   (cvt_bcd)
  );

  // Conversion sequencer: field 0 then field 1, both committed together at the end
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      cstate   <= C_IDLE;
      n1_lat   <= '0;
      bcd0_tmp <= '0;
      disp0    <= '0;
      disp1    <= '0;
    end else begin
      case (cstate)
        C_IDLE: if (vrise && !cvt_busy) begin
          cstate <= C_CONV0;
          n1_lat <= io.number1;
        end
        C_CONV0: if (cvt_done) begin
          cstate   <= C_CONV1;
          bcd0_tmp <= cvt_bcd;
        end
        C_CONV1: if (cvt_done) begin
          cstate <= C_IDLE;
          disp0  <= bcd0_tmp;
          disp1  <= cvt_bcd;
        end
        default: cstate <= C_IDLE;
      endcase
    end
  end

  // Next-line window, glyph line and pixel position decode (borrow bit = left/above the field)
  always_comb begin
    nl      = (io.vcount == V_LAST) ? 11'd0 : io.vcount + 11'd1;
    dy0     = {1'b0, nl} - {1'b0, YPOS0};
    dy1     = {1'b0, nl} - {1'b0, YPOS1};
    hit0_t  = !dy0[11] && (dy0[10:0] < WIN_H);
    hit1_t  = !dy1[11] && (dy1[10:0] < WIN_H);
    line0_t = 4'(dy0[10:0] >> SCALE_LOG2);
    line1_t = 4'(dy1[10:0] >> SCALE_LOG2);

    cur_keep = ((slot >= 3'd3) ? hit1 : hit0) && !slot_blank(slot, disp0, disp1, LEAD_BLANK);
    nslot    = slot + 3'd1;
    naddr    = rom_pack(slot_digit(nslot, disp0, disp1), (nslot >= 3'd3) ? line1 : line0);
    taddr    = rom_pack(slot_digit(3'd0, disp0, disp1), line0_t);

    px0    = {1'b0, io.hcount} - {1'b0, XPOS0};
    px1    = {1'b0, io.hcount} - {1'b0, XPOS1};
    in0    = !px0[11] && (px0[10:0] < FIELD_W);
    in1    = !px1[11] && (px1[10:0] < FIELD_W);
    dsel   = in0 ? px0[10:0] : px1[10:0];
    dig    = 2'(dsel >> (3 + SCALE_LOG2));
    bsel   = 3'd7 - 3'(dsel >> SCALE_LOG2);
    pslot  = in0 ? {1'b0, dig} : {1'b0, dig} + 3'd3;
    pix_on = (in0 || in1) && !io.hblnk && !io.vblnk && active[pslot][bsel];
  end

  // Glyph prefetch: one rom read per cycle into the shadow rows, swapped in at end of hblank
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      fstate   <= F_IDLE;
      slot     <= '0;
      line0    <= '0;
      line1    <= '0;
      hit0     <= 1'b0;
      hit1     <= 1'b0;
      io.rom_addr <= '0;
      shadow   <= '0;
      active   <= '0;
    end else begin
      case (fstate)
        F_IDLE: if (hrise) begin
          fstate      <= F_FETCH;
          slot        <= 3'd0;
          line0       <= line0_t;
          line1       <= line1_t;
          hit0        <= hit0_t;
          hit1        <= hit1_t;
          io.rom_addr <= taddr;
        end
        F_FETCH: begin
          if (hfall) begin
            fstate <= F_IDLE;
            active <= '0;
          end else begin
            shadow[slot] <= cur_keep ? io.rom_data : 8'h00;
            if (slot == 3'(FETCH_SLOTS - 1)) begin
              fstate <= F_DONE;
            end else begin
              slot        <= nslot;
              io.rom_addr <= naddr;
            end
          end
        end
        F_DONE: if (hfall) begin
          fstate <= F_IDLE;
          active <= shadow;
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

  // Registered pixel; field 0 owns any overlap
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      io.pixel     <= 1'b0;
      io.pixel_fld <= 1'b0;
    end else begin
      io.pixel     <= pix_on;
      io.pixel_fld <= pix_on && !in0;
    end
  end

  assign io.conv_busy   = (cstate == C_CONV0) || (cstate == C_CONV1);
  assign io.conv_state  = cstate;
  assign io.fetch_state = fstate;

endmodule

// File: tb/tb_number_overlay_ctrl.sv
// Self-checking bench for number_overlay_ctrl with a behavioural frame model.
module tb_number_overlay_ctrl;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  number_overlay_ctrl_if bus ();

  number_overlay_ctrl dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  // Golden char_rom contents (any fixed pattern works as long as both sides agree)
  function automatic logic [7:0] glyph(input logic [7:0] a);
    logic [7:0] t;
    t = a * 8'd53;
    return t ^ 8'h3C;
  endfunction

  assign bus.rom_data = glyph(bus.rom_addr);

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  int m_n0 = 0;
  int m_n1 = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal digit d (0 = hundreds, 1 = tens, 2 = ones) of n
  function automatic int dec_digit(input int n, input int d);
    if (d == 0) return n / 100;
    if (d == 1) return (n / 10) % 10;
    return n % 10;
  endfunction

  // Expected {pixel_fld, pixel} at screen column x of line nl
  function automatic logic [7:0] model_pix(input int x, input int nl, input bit blank);
    int f, xp, n, di, dv;
    logic [7:0] row;
    logic [7:0] gaddr;
    if (blank) return 8'h00;
    if (x >= 0 && x < 192) begin f = 0; xp = 0; end
    else if (x >= 400 && x < 592) begin f = 1; xp = 400; end
    else return 8'h00;
    if (nl >= 128) return 8'h00;
    n  = (f == 1) ? m_n1 : m_n0;
    di = (x - xp) / 64;
    if (di == 0 && n < 100) return 8'h00;
    if (di == 1 && n < 10) return 8'h00;
    dv = dec_digit(n, di);
    gaddr = {4'(dv), 4'(nl / 8)};
    row = glyph(gaddr);
    if (row[7 - ((x - xp) / 8) % 8]) return (f == 1) ? 8'h03 : 8'h01;
    return 8'h00;
  endfunction

  task automatic do_reset();
    @(negedge pclk);
    rst_n = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_pixel", {7'd0, bus.pixel}, 8'h00);
    check("reset_pixel_fld", {7'd0, bus.pixel_fld}, 8'h00);
    check("reset_conv_busy", {7'd0, bus.conv_busy}, 8'h00);
    check("reset_rom_addr", bus.rom_addr, 8'h00);
    @(negedge pclk);
    rst_n = 1'b1;
    m_n0 = 0;
    m_n1 = 0;
  endtask

  // vblank pulse: converts a/b; optional extra vblnk edge while busy; inputs change mid-CONV1
  task automatic run_vblank(input logic [7:0] a, input logic [7:0] b, input bit glitch,
                            input logic [7:0] late);
    int cnt;
    logic first;
    cnt = 0;
    first = 1'b0;
    @(negedge pclk);
    bus.number0 = a;
    bus.number1 = b;
    bus.vblnk   = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge pclk);
      #1;
      if (c == 0) first = bus.conv_busy;
      if (bus.conv_busy) cnt++;
      if (glitch && c == 4) bus.vblnk = 1'b0;
      if (glitch && c == 6) bus.vblnk = 1'b1;
      if (c == 11) begin
        bus.number0 = late;
        bus.number1 = late ^ 8'hFF;
      end
    end
    check("conv_busy_start", {7'd0, first}, 8'h01);
    check("conv_busy_len", 8'(cnt), 8'd16);
    @(negedge pclk);
    bus.vblnk = 1'b0;
    m_n0 = int'(a);
    m_n1 = int'(b);
  endtask

  // One hblank of hb_len cycles after line y, then a 600-pixel sweep of the next line
  task automatic run_line(input int y, input int hb_len, input bit chk_addr, input bit vb_on);
    int nl;
    bit blank;
    nl = (y == 627) ? 0 : y + 1;
    blank = (hb_len < 7) || vb_on;
    @(negedge pclk);
    bus.vcount = 11'(y);
    bus.hblnk  = 1'b1;
    if (chk_addr) begin
      for (int f = 0; f < 2; f++)
        for (int d = 0; d < 3; d++)
          exp_q.push_back({4'(dec_digit((f == 1) ? m_n1 : m_n0, d)), 4'(nl / 8)});
    end
    for (int c = 0; c < hb_len; c++) begin
      @(posedge pclk);
      #1;
      if (chk_addr && c < 6) check("rom_addr", bus.rom_addr, exp_q.pop_front());
    end
    @(negedge pclk);
    bus.hblnk  = 1'b0;
    bus.vcount = 11'(nl);
    bus.vblnk  = vb_on;
    for (int h = 0; h < 600; h++) begin
      @(negedge pclk);
      bus.hcount = 11'(h);
      exp_q.push_back(model_pix(h, nl, blank));
      @(posedge pclk);
      #1;
      check("pixel", {6'd0, bus.pixel_fld, bus.pixel}, exp_q.pop_front());
    end
    @(negedge pclk);
    bus.hcount = 11'd2000;
    bus.vblnk  = 1'b0;
    if (vb_on) begin
      m_n0 = int'(bus.number0);
      m_n1 = int'(bus.number1);
    end
  endtask

  initial begin
    int hb;
    bus.number0 = 8'd0;
    bus.number1 = 8'd0;
    bus.hcount  = 11'd2000;
    bus.vcount  = 11'd0;
    bus.hblnk   = 1'b0;
    bus.vblnk   = 1'b0;

    do_reset();
    // First frame after reset: only the ones digit "0" of each field
    run_line(9, 8, 1'b1, 1'b0);

    // 255 / 7 with an ignored vblnk edge and a late input change; prefetch at line 8
    run_vblank(8'd255, 8'd7, 1'b1, 8'd99);
    run_line(7, 10, 1'b1, 1'b0);

    // Leading-zero blanking cases
    run_vblank(8'd5, 8'd200, 1'b0, 8'd0);
    run_line(40, 7, 1'b1, 1'b0);
    run_vblank(8'd105, 8'd50, 1'b0, 8'd0);
    run_line(100, 9, 1'b1, 1'b0);

    // Short hblank blanks the line, the following line recovers
    run_line(60, 4, 1'b0, 1'b0);
    run_line(61, 8, 1'b1, 1'b0);

    // Last line of frame wraps to line 0
    run_line(627, 8, 1'b1, 1'b0);

    // Pixels forced off during vblank
    run_line(20, 8, 1'b0, 1'b1);
    run_line(21, 8, 1'b1, 1'b0);

    // Reset in the middle of a conversion
    @(negedge pclk);
    bus.number0 = 8'd123;
    bus.vblnk   = 1'b1;
    repeat (5) @(posedge pclk);
    #1;
    rst_n = 1'b0;
    @(posedge pclk);
    #1;
    check("midreset_conv_busy", {7'd0, bus.conv_busy}, 8'h00);
    check("midreset_rom_addr", bus.rom_addr, 8'h00);
    check("midreset_pixel", {7'd0, bus.pixel}, 8'h00);
    @(negedge pclk);
    rst_n     = 1'b1;
    bus.vblnk = 1'b0;
    m_n0 = 0;
    m_n1 = 0;
    run_line(3, 8, 1'b1, 1'b0);

    // Randomized frames
    for (int i = 0; i < 10; i++) begin
      run_vblank(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      for (int j = 0; j < 2; j++) begin
        hb = $urandom_range(4, 12);
        run_line($urandom_range(0, 140), hb, hb >= 6, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
